load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 72 +++++++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared constants and types for the load/store unit: access codes, FSM states, lane widths.
package load_store_unit_pkg;

    localparam int BE_W  = 4;
    localparam int TMO_W = 16;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    localparam logic [1:0] ST_SB = 2'b00;
    localparam logic [1:0] ST_SH = 2'b01;
    localparam logic [1:0] ST_SW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_DONE
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } acc_size_t;

    typedef struct packed {
        logic      legal;
        acc_size_t size;
        logic      sext;
    } acc_dec_t;

    function automatic acc_dec_t decode_access(input logic       is_write,
                                               input logic [2:0] ld_code,
                                               input logic [1:0] st_code);
        acc_dec_t d;
        d.legal = 1'b1;
        d.size  = SZ_WORD;
        d.sext  = 1'b0;
        if (is_write) begin
            case (st_code)
                ST_SB:   d.size = SZ_BYTE;
                ST_SH:   d.size = SZ_HALF;
                ST_SW:   d.size = SZ_WORD;
                default: d.legal = 1'b0;
            endcase
        end else begin
            case (ld_code)
                LD_LB:   begin d.size = SZ_BYTE; d.sext = 1'b1; end
                LD_LH:   begin d.size = SZ_HALF; d.sext = 1'b1; end
                LD_LW:   d.size = SZ_WORD;
                LD_LBU:  d.size = SZ_BYTE;
                LD_LHU:  d.size = SZ_HALF;
                default: d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

    // Drops the address bits below the access size so lanes line up with a naturally aligned slot.
    function automatic logic [1:0] align_lo(input acc_size_t size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return lo;
            SZ_HALF: return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-wide memory bus between the load/store unit (master) and the memory side (slave).
interface load_store_unit_if;
    import load_store_unit_pkg::*;

    logic            busReqValid;
    logic            busReqReady;
    logic            busWrite;
    logic [31:0]     busAddr;
    logic [31:0]     busWData;
    logic [BE_W-1:0] busByteEn;
    logic            busRspValid;
    logic [31:0]     busRData;

    modport master (
        output busReqValid, busWrite, busAddr, busWData, busByteEn,
        input  busReqReady, busRspValid, busRData
    );

    modport slave (
        input  busReqValid, busWrite, busAddr, busWData, busByteEn,
        output busReqReady, busRspValid, busRData
    );

endinterface

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane steering: store byte-enables/data replication and load extraction with extension.
// No state, zero latency; no handshake of its own.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  acc_size_t       req_size,
    input  logic [1:0]      req_lo,
    input  logic [31:0]     store_data,
    output logic [BE_W-1:0] byte_en,
    output logic [31:0]     wdata,
    input  acc_size_t       rsp_size,
    input  logic            rsp_sext,
    input  logic [1:0]      rsp_lo,
    input  logic [31:0]     rdata,
    output logic [31:0]     load_value
);

    logic [31:0] shifted;

    always_comb begin
        byte_en = '0;
        wdata   = '0;
        case (req_size)
            SZ_BYTE: begin
                byte_en = 4'b0001 << req_lo;
                wdata   = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                byte_en = req_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{store_data[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wdata   = store_data;
            end
        endcase
    end

    always_comb begin
        shifted    = rdata >> {rsp_lo, 3'b000};
        load_value = rdata;
        case (rsp_size)
            SZ_BYTE: load_value = {{24{rsp_sext & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_value = {{16{rsp_sext & shifted[15]}}, shifted[15:0]};
            default: load_value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding sub-word/word access over a valid/ready bus with response timeout.
// Latency: memReq cycle N -> done N+3 on a zero-wait bus; busReqValid holds until busReqReady.
// Backpressure: stall held from acceptance until done/abort. LSU_MISALIGN_TRAP_EN faults misaligned accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              memReq,
    input  logic              memWrite,
    input  logic [2:0]        loadCtrl,
    input  logic [1:0]        storeCtrl,
    input  logic [31:0]       addr,
    input  logic [31:0]       storeData,
    output logic              stall,
    output logic [31:0]       loadData,
    output logic              done,
    output logic              fault,
    load_store_unit_if.master bus
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t      state_q, state_d;
    acc_dec_t        dec;
    logic            misaligned;
    logic            accept;
    logic            reject;
    logic [1:0]      lo_aligned;
    logic            rsp_take;
    logic            tmo_abort;

    logic            wr_q;
    acc_size_t       size_q;
    logic            sext_q;
    logic [1:0]      lo_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [BE_W-1:0] be_q;
    logic [31:0]     load_q;
    logic            fault_q;
    logic [TMO_W-1:0] tmo_cnt_q;

    logic [BE_W-1:0] align_be;
    logic [31:0]     align_wdata;
    logic [31:0]     load_value;

    always_comb begin
        dec        = decode_access(memWrite, loadCtrl, storeCtrl);
        lo_aligned = align_lo(dec.size, addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        misaligned = (dec.size == SZ_HALF && addr[0]) ||
                     (dec.size == SZ_WORD && addr[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        accept    = (state_q == S_IDLE) && memReq && dec.legal && !misaligned;
        reject    = (state_q == S_IDLE) && memReq && !(dec.legal && !misaligned);
        rsp_take  = (state_q == S_WAIT_RSP) && bus.busRspValid;
        // A response landing on the terminal count still completes the access.
        tmo_abort = (state_q == S_WAIT_RSP) && !bus.busRspValid && (tmo_cnt_q == TMO_LAST);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_REQ;
            S_REQ:      if (bus.busReqReady) state_d = S_WAIT_RSP;
            S_WAIT_RSP: begin
                if (bus.busRspValid)  state_d = S_DONE;
                else if (tmo_abort)   state_d = S_IDLE;
            end
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    lsu_lane_align u_lane_align (
        .req_size   (dec.size),
        .req_lo     (lo_aligned),
        .store_data (storeData),
        .byte_en    (align_be),
        .wdata      (align_wdata),
        .rsp_size   (size_q),
        .rsp_sext   (sext_q),
        .rsp_lo     (lo_q),
        .rdata      (bus.busRData),
        .load_value (load_value)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            wr_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            sext_q    <= 1'b0;
            lo_q      <= 2'b00;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            load_q    <= '0;
            fault_q   <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= memWrite;
                size_q  <= dec.size;
                sext_q  <= dec.sext;
                lo_q    <= lo_aligned;
                addr_q  <= {addr[31:2], 2'b00};
                wdata_q <= align_wdata;
                be_q    <= align_be;
            end
            if (state_q == S_REQ && bus.busReqReady) tmo_cnt_q <= '0;
            else if (state_q == S_WAIT_RSP)          tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
            if (rsp_take && !wr_q) load_q <= load_value;
            fault_q <= reject || tmo_abort;
        end
    end

    // Gated by rstN so a pending legal memReq cannot raise stall while held in reset.
    assign stall    = rstN && (accept || state_q == S_REQ || state_q == S_WAIT_RSP);
    assign done     = (state_q == S_DONE);
    assign fault    = fault_q;
    assign loadData = load_q;

    assign bus.busReqValid = (state_q == S_REQ);
    assign bus.busWrite    = wr_q;
    assign bus.busAddr     = addr_q;
    assign bus.busWData    = wdata_q;
    assign bus.busByteEn   = be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized scoreboard bench for load_store_unit against a byte-arithmetic reference model.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rstN;
    logic        memReq, memWrite;
    logic [2:0]  loadCtrl;
    logic [1:0]  storeCtrl;
    logic [31:0] addr, storeData;
    logic        stall, done, fault;
    logic [31:0] loadData;

    load_store_unit_if bus_if();

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rstN(rstN), .memReq(memReq), .memWrite(memWrite),
        .loadCtrl(loadCtrl), .storeCtrl(storeCtrl), .addr(addr), .storeData(storeData),
        .stall(stall), .loadData(loadData), .done(done), .fault(fault), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        int          cyc;
    } bus_exp_t;

    typedef struct {
        bit          is_fault;
        int          cyc;
        logic [31:0] ld;
    } evt_exp_t;

    bus_exp_t    bus_q[$];
    evt_exp_t    evt_q[$];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          busy_lo = 0;
    int          busy_hi = -1;
    logic [31:0] last_load = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: stall window, bus request fields, completion events.
    always @(negedge clk) begin
        bus_exp_t be_e;
        evt_exp_t ev;
        chk("stall", 32'(stall), 32'(cyc >= busy_lo && cyc <= busy_hi));
        if (bus_if.busReqValid) begin
            if (bus_q.size() == 0) chk("spurious_busReqValid", 32'(bus_if.busReqValid), 32'd0);
            else begin
                be_e = bus_q[0];
                chk("busWrite", 32'(bus_if.busWrite), 32'(be_e.wr));
                chk("busAddr", bus_if.busAddr, be_e.a);
                chk("busByteEn", 32'(bus_if.busByteEn), 32'(be_e.be));
                if (be_e.wr) chk("busWData", bus_if.busWData, be_e.wd);
                if (bus_if.busReqReady) begin
                    chk("handshake_cycle", 32'(cyc), 32'(be_e.cyc));
                    void'(bus_q.pop_front());
                end
            end
        end
        if (done || fault) begin
            if (evt_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
                chk("spurious_fault", 32'(fault), 32'd0);
            end else begin
                ev = evt_q.pop_front();
                chk("done", 32'(done), 32'(!ev.is_fault));
                chk("fault", 32'(fault), 32'(ev.is_fault));
                chk("event_cycle", 32'(cyc), 32'(ev.cyc));
                if (!ev.is_fault) chk("loadData", loadData, ev.ld);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_busReqValid", 32'(bus_if.busReqValid), 32'd0);
        chk("rst_busWrite", 32'(bus_if.busWrite), 32'd0);
        chk("rst_busAddr", bus_if.busAddr, 32'd0);
        chk("rst_busWData", bus_if.busWData, 32'd0);
        chk("rst_busByteEn", 32'(bus_if.busByteEn), 32'd0);
        chk("rst_loadData", loadData, 32'd0);
    endtask

    // One access: model predicts bus fields, completion kind/cycle and load result; bus is driven to the given timing.
    task automatic run_txn(input bit wr, input logic [2:0] lc, input logic [1:0] sc,
                           input logic [31:0] a, input logic [31:0] sd,
                           input int rdy_dly, input int rsp_dly, input logic [31:0] rd);
        int          n, nbytes, lo, off, hs, endc, rsp_cyc;
        bit          legal, sext, timeout;
        logic [31:0] v, wd;
        logic [3:0]  be;
        bus_exp_t    bx;
        evt_exp_t    ex;

        legal  = wr ? (sc != 2'b11) : (lc inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        nbytes = wr ? (1 << sc) : (1 << lc[1:0]);
        sext   = !wr && !lc[2] && nbytes < 4;
        lo     = int'(a[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((lo % nbytes) != 0) legal = 1'b0;
`endif
        off = lo - (lo % nbytes);
        be  = 4'(((1 << nbytes) - 1) << off);
        wd  = 32'h0;
        for (int b = 0; b < 4; b++) wd[8*b +: 8] = sd[8*(b % nbytes) +: 8];
        v = rd >> (8 * off);
        if (nbytes == 1)      v = (sext && v[7])  ? {24'hFFFFFF, v[7:0]}  : {24'h0, v[7:0]};
        else if (nbytes == 2) v = (sext && v[15]) ? {16'hFFFF, v[15:0]}   : {16'h0, v[15:0]};
        timeout = rsp_dly >= TMO;

        @(posedge clk); #1;
        n = cyc;
        memReq = 1'b1; memWrite = wr; loadCtrl = lc; storeCtrl = sc; addr = a; storeData = sd;
        hs = n + 1 + rdy_dly;
        rsp_cyc = hs + 1 + rsp_dly;
        if (!legal) begin
            endc = n + 1;
            busy_lo = n + 1; busy_hi = n;
            ex.is_fault = 1'b1; ex.cyc = endc; ex.ld = last_load;
            evt_q.push_back(ex);
        end else begin
            endc = timeout ? hs + 1 + TMO : rsp_cyc + 1;
            busy_lo = n; busy_hi = endc - 1;
            bx.wr = wr; bx.a = {a[31:2], 2'b00}; bx.be = be; bx.wd = wd; bx.cyc = hs;
            bus_q.push_back(bx);
            if (!wr && !timeout) last_load = v;
            ex.is_fault = timeout; ex.cyc = endc; ex.ld = last_load;
            evt_q.push_back(ex);
        end

        for (int c = n + 1; c <= endc; c++) begin
            @(posedge clk); #1;
            memReq = 1'b0; memWrite = 1'($urandom); loadCtrl = 3'($urandom); storeCtrl = 2'($urandom);
            addr = $urandom; storeData = $urandom;
            if (!legal)       bus_if.busReqReady = 1'b1;
            else if (c == hs) bus_if.busReqReady = 1'b1;
            else if (c < hs)  bus_if.busReqReady = 1'b0;
            else              bus_if.busReqReady = 1'($urandom);
            bus_if.busRData = $urandom;
            if (legal && !timeout && c == rsp_cyc) begin
                bus_if.busRspValid = 1'b1;
                bus_if.busRData = rd;
            end else if (c <= hs || c == endc) bus_if.busRspValid = 1'($urandom);
            else bus_if.busRspValid = 1'b0;
        end
        @(posedge clk); #1;
        bus_if.busReqReady = 1'b0;
        bus_if.busRspValid = 1'b0;
    endtask

    initial begin
        int n;
        rstN = 1'b0;
        memReq = 1'b0; memWrite = 1'b0; loadCtrl = 3'b000; storeCtrl = 2'b00;
        addr = 32'h0; storeData = 32'h0;
        bus_if.busReqReady = 1'b0; bus_if.busRspValid = 1'b0; bus_if.busRData = 32'h0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        rstN = 1'b1;

        run_txn(1'b1, 3'b000, 2'b00, 32'h0000_1003, 32'h0000_00AB, 0, 0, 32'h0);
        run_txn(1'b0, 3'b000, 2'b00, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_8000);
        run_txn(1'b0, 3'b100, 2'b00, 32'h0000_2001, 32'h0, 0, 0, 32'h0000_8000);
        run_txn(1'b0, 3'b001, 2'b00, 32'h0000_3002, 32'h0, 3, 1, 32'h8001_0000);
        run_txn(1'b0, 3'b010, 2'b00, 32'h0000_5000, 32'h0, 0, 9, 32'hDEAD_BEEF);
        run_txn(1'b0, 3'b010, 2'b00, 32'h0000_5004, 32'h0, 0, TMO - 1, 32'h1234_5678);
        run_txn(1'b0, 3'b010, 2'b00, 32'h0000_4002, 32'h0, 0, 0, 32'hCAFE_F00D);
        run_txn(1'b1, 3'b000, 2'b11, 32'h0000_6000, 32'h5555_AAAA, 0, 0, 32'h0);
        run_txn(1'b1, 3'b000, 2'b10, 32'h0000_7000, 32'h0BAD_CAFE, 1, 0, 32'h0);

        for (int i = 0; i < 300; i++)
            run_txn(1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, TMO + 1), $urandom);

        // Reset while an access sits in WAIT_RSP.
        @(posedge clk); #1;
        n = cyc;
        memReq = 1'b1; memWrite = 1'b0; loadCtrl = 3'b010; addr = 32'h0000_8000;
        bus_q.push_back('{1'b0, 32'h0000_8000, 4'b1111, 32'h0, n + 1});
        busy_lo = n; busy_hi = n + 1000;
        @(posedge clk); #1; memReq = 1'b0; bus_if.busReqReady = 1'b1;
        @(posedge clk); #1; bus_if.busReqReady = 1'b0;
        @(posedge clk); #1;
        rstN = 1'b0; busy_hi = -1; last_load = 32'h0;
        memReq = 1'b1;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #1 memReq = 1'b0; rstN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1 bus_if.busRspValid = 1'($urandom); bus_if.busRData = $urandom;
        end
        bus_if.busRspValid = 1'b0;
        run_txn(1'b0, 3'b101, 2'b00, 32'h0000_9003, 32'h0, 0, 0, 32'hF00F_1234);

        for (int i = 0; i < 20 && (evt_q.size() != 0 || bus_q.size() != 0); i++) @(posedge clk);
        chk("evt_queue_drained", 32'(evt_q.size()), 32'd0);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
